if_fetch_queue: RTL
===================

Name: if_fetch_queue

Overview:
Instruction-fetch front end of the `main` RISC-V core.
- Owns the PC and issues word-aligned instruction-memory requests.
- Buffers in-order responses in a DEPTH-entry tagged queue and presents {pc, instruction} to decode over a valid/ready handshake.
- Handles branch/jump redirects from execute by flushing the queue and discarding stale in-flight responses.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC loaded on reset
DEPTH, 4, queue entries; power of 2, >=2

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous, active-low; sampled on rising edge of clk
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  XLEN  request address, bits[1:0] always 0
imem_rsp_valid  input  1  one response per accepted request, in order, >=1 cycle after acceptance
imem_rdata  input  32  response instruction word
inst_valid  output  1  head entry valid to decode
inst_ready  input  1  decode accepts head
inst_data  output  32  head instruction
inst_pc  output  XLEN  head PC
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  XLEN  new PC; bits[1:0] ignored (treated as 0)

Behaviour:
- State:
  - pc register.
  - Circular queue: entry = {pc, data, filled}, with head, tail and alloc pointers.
  - reserved count (0..DEPTH), number of allocated entries.
  - live count, allocated but unfilled entries.
  - discard count (0..DEPTH).
- Reset (reset==0 at a clock edge):
  - pc<=RESET_PC; reserved, live and discard <=0; pointers <=0; all filled <=0.
  - While reset is low: imem_req_valid=0 and inst_valid=0.
  - Reset mid-operation aborts everything. Responses for requests accepted before reset are not tracked, so memory must also be reset.
- Issue:
  - imem_req_valid = reset & !redirect_valid & (reserved + discard < DEPTH).
  - imem_addr = pc.
  - On accept (valid & ready): allocate the tail entry tagged with pc (filled=0), pc<=pc+4 (wraps mod 2^XLEN), reserved++, live++.
  - No request is issued in the reset-release cycle's predecessor. The first request can appear in the first cycle with reset high.
- Response:
  - If discard>0: the response is dropped and discard--.
  - Otherwise: it fills the oldest unfilled entry (alloc pointer) with imem_rdata, and live--.
  - A response with no outstanding request is a protocol error; behaviour is undefined.
- Output:
  - inst_valid = reset & !redirect_valid & head.filled.
  - inst_data and inst_pc come from the head entry.
  - Pop on inst_valid & inst_ready: head++, reserved--.
  - Fill-to-output latency is 1 cycle; a filled entry is visible the cycle after the response.
  - Minimum fetch latency (request accept to inst_valid) = memory latency + 1.
- Simultaneous events in one cycle: accept, response and pop may all occur. Counters update by net amount, e.g. reserved stays DEPTH-1 on accept+pop.
- Full: reserved+discard==DEPTH, so imem_req_valid=0. A pop in the same cycle does not re-enable the request until the next cycle (registered counts).
- Empty, or head unfilled: inst_valid=0, and inst_data/inst_pc are don't-care.
- Redirect (redirect_valid=1 and reset=1), takes priority over everything:
  - No request and no pop that cycle.
  - All entries are invalidated: reserved<=0, live<=0, pointers<=0.
  - discard <= discard + live - (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is dropped.
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - The next cycle may issue a request at the new pc (subject to the full rule).
  - Back-to-back redirects: each one applies; the last one wins.
- Counter widths: clog2(DEPTH)+1 bits. No overflow is possible under the issue gate.

Test Plan:
1. Reset and basic fetch: reset low 2 cycles then high; memory with 1-cycle latency, always ready; inst_ready=1. Expect requests at 0x0, 0x4, 0x8, ... on consecutive cycles; inst_pc 0x0, 0x4, ... with matching data; first inst_valid 2 cycles after the first accept.
2. Backpressure/full: inst_ready=0, DEPTH=4. Expect exactly 4 requests (0x0–0xC), then imem_req_valid=0. Raise inst_ready: pops 0x0 first, and the request for 0x10 follows one cycle after the first pop.
3. Memory stall: imem_req_ready=0 for 5 cycles. Expect imem_addr held at the same pc and no pc advance; issue resumes on ready.
4. Redirect with in-flight requests: 3-cycle memory latency, 2 outstanding; assert redirect_pc=0x103 for 1 cycle. Expect both stale responses dropped; next request at 0x100; first inst_pc=0x100 carries the data from the 0x100 response; inst_valid=0 during the redirect cycle.
5. Redirect coinciding with a response and a pop: expect no handshake completing that cycle, discard = live-1, and no stale instruction ever delivered.
6. Reset mid-operation: queue holding 3 entries, reset low 1 cycle. Expect inst_valid=0 and imem_req_valid=0 that cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_queue_if.sv
// Fetch front-end bundle: imem request/response, decode handshake and redirect.
// master is the fetch queue; slave is the memory/decode/execute side.
interface if_fetch_queue_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rdata;
   logic            inst_valid;
   logic            inst_ready;
   logic [31:0]     inst_data;
   logic [XLEN-1:0] inst_pc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   modport master (
      output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rdata, inst_ready,
             redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
      output imem_req_ready, imem_rsp_valid, imem_rdata, inst_ready,
             redirect_valid, redirect_pc
   );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues imem requests, buffers in-order
// responses in a tagged circular queue and drops stale responses after a redirect.
module if_fetch_queue #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 4
) (
   input  logic          clk,
   input  logic          reset,
   if_fetch_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [XLEN-1:0] pc_reg, pc_next;
   logic [PW-1:0]   head_reg, head_next;
   logic [PW-1:0]   tail_reg, tail_next;
   logic [PW-1:0]   alloc_reg, alloc_next;
   logic [CW-1:0]   reserved_reg, reserved_next;
   logic [CW-1:0]   live_reg, live_next;
   logic [CW-1:0]   discard_reg, discard_next;

   logic [XLEN-1:0] entry_pc_reg   [DEPTH];
   logic [31:0]     entry_data_reg [DEPTH];
   logic [DEPTH-1:0] filled_reg;

   logic [CW:0] occupancy;
   logic        redirect;
   logic        req_valid;
   logic        accept;
   logic        drop;
   logic        fill;
   logic        inst_valid;
   logic        pop;

   // Stale in-flight responses still hold a slot until they drain.
   assign occupancy  = {1'b0, reserved_reg} + {1'b0, discard_reg};
   assign redirect   = reset & bus.redirect_valid;
   assign req_valid  = reset & ~bus.redirect_valid & (occupancy < DEPTH_W);
   assign accept     = req_valid & bus.imem_req_ready;
   assign drop       = bus.imem_rsp_valid & (discard_reg != '0);
   assign fill       = bus.imem_rsp_valid & (discard_reg == '0) & ~redirect;
   assign inst_valid = reset & ~bus.redirect_valid & filled_reg[head_reg];
   assign pop        = inst_valid & bus.inst_ready;

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_addr      = {pc_reg[XLEN-1:2], 2'b00};
   assign bus.inst_valid     = inst_valid;
   assign bus.inst_data      = entry_data_reg[head_reg];
   assign bus.inst_pc        = entry_pc_reg[head_reg];

   always_comb begin
      pc_next       = pc_reg;
      head_next     = head_reg;
      tail_next     = tail_reg;
      alloc_next    = alloc_reg;
      reserved_next = reserved_reg;
      live_next     = live_reg;
      discard_next  = discard_reg;
      if (redirect) begin
         // Everything still outstanding becomes stale; a response this cycle is one of them.
         pc_next       = {bus.redirect_pc[XLEN-1:2], 2'b00};
         head_next     = '0;
         tail_next     = '0;
         alloc_next    = '0;
         reserved_next = '0;
         live_next     = '0;
         discard_next  = discard_reg + live_reg - CW'(bus.imem_rsp_valid);
      end else begin
         if (accept) begin
            pc_next   = pc_reg + XLEN'(4);
            tail_next = tail_reg + PW'(1);
         end
         if (fill) begin
            alloc_next = alloc_reg + PW'(1);
         end
         if (pop) begin
            head_next = head_reg + PW'(1);
         end
         reserved_next = reserved_reg + CW'(accept) - CW'(pop);
         live_next     = live_reg + CW'(accept) - CW'(fill);
         discard_next  = discard_reg - CW'(drop);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_reg       <= RESET_PC;
         head_reg     <= '0;
         tail_reg     <= '0;
         alloc_reg    <= '0;
         reserved_reg <= '0;
         live_reg     <= '0;
         discard_reg  <= '0;
      end else begin
         pc_reg       <= pc_next;
         head_reg     <= head_next;
         tail_reg     <= tail_next;
         alloc_reg    <= alloc_next;
         reserved_reg <= reserved_next;
         live_reg     <= live_next;
         discard_reg  <= discard_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic tail_hit, alloc_hit, head_hit;
         assign tail_hit  = accept & (tail_reg == PW'(gi));
         assign alloc_hit = fill & (alloc_reg == PW'(gi));
         assign head_hit  = pop & (head_reg == PW'(gi));

         always_ff @(posedge clk) begin
            if (!reset || redirect) begin
               filled_reg[gi] <= 1'b0;
            end else if (alloc_hit) begin
               filled_reg[gi] <= 1'b1;
            end else if (head_hit || tail_hit) begin
               filled_reg[gi] <= 1'b0;
            end
         end

         // Payload needs no reset: it is only observed when filled is set.
         always_ff @(posedge clk) begin
            if (tail_hit) begin
               entry_pc_reg[gi] <= pc_reg;
            end
            if (alloc_hit) begin
               entry_data_reg[gi] <= bus.imem_rdata;
            end
         end
      end
   endgenerate
endmodule
